// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq
// Iterative multi-mode shifter (ROL / SLL / ROR / SRA) that walks the operand
// one bit position per clock. It is a start/done co-unit that trades latency
// for area compared with a single-cycle barrel shifter.
//
// Optional build macro: SHIFTER_SEQ_STEP4_EN
//   When defined, the unit moves four positions in one clock while at least
//   four positions remain. It then finishes with single steps. Results are
//   identical to the single-step build; only latency changes.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous, active-high reset (priority over everything)
//   start    : request, accepted only in IDLE or DONE
//   in_data  : operand, captured on the accepting edge
//   sh_amt   : unsigned shift amount, captured on the accepting edge
//   mode     : 00 ROL, 01 SLL, 10 ROR, 11 SRA, captured on the accepting edge
//   out_data : result register, written only on entry to DONE
//   busy     : high while shifting
//   done     : one-cycle pulse, out_data valid from this cycle onward
// -----------------------------------------------------------------------------
module shifter_seq #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] in_data,
  input  logic [SHAMT_WIDTH-1:0]   sh_amt,
  input  logic [1:0]               mode,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int W = OPERAND_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [W-1:0]           wr_reg, wr_next;
  logic [SHAMT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [1:0]             md_reg, md_next;
  logic [W-1:0]           out_next;
  logic                   accept;

  // One position in the direction/fill selected by m.
  function automatic logic [W-1:0] step1(input logic [W-1:0] v, input logic [1:0] m);
    case (m)
      2'b00:   step1 = {v[W-2:0], v[W-1]};   // ROL
      2'b01:   step1 = {v[W-2:0], 1'b0};     // SLL
      2'b10:   step1 = {v[0], v[W-1:1]};     // ROR
      default: step1 = {v[W-1], v[W-1:1]};   // SRA
    endcase
  endfunction

`ifdef SHIFTER_SEQ_STEP4_EN
  // Four chained single steps: guarantees bit-identical results to the
  // single-step build, and synthesises to a flat 4-position mux.
  function automatic logic [W-1:0] step4(input logic [W-1:0] v, input logic [1:0] m);
    step4 = step1(step1(step1(step1(v, m), m), m), m);
  endfunction
`endif

  // A new request can be taken whenever the unit is not mid-shift.
  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    busy = (state_reg == SHIFT);
    done = (state_reg == DONE);
  end

  // Datapath next values
  always_comb begin
    wr_next  = wr_reg;
    cnt_next = cnt_reg;
    md_next  = md_reg;
    out_next = out_data;
    if (accept) begin
      wr_next  = in_data;
      cnt_next = sh_amt;
      md_next  = mode;
    end else if (state_reg == SHIFT) begin
      if (cnt_reg == '0) begin
        out_next = wr_reg;
`ifdef SHIFTER_SEQ_STEP4_EN
      end else if (cnt_reg >= SHAMT_WIDTH'(4)) begin
        wr_next  = step4(wr_reg, md_reg);
        cnt_next = cnt_reg - SHAMT_WIDTH'(4);
`endif
      end else begin
        wr_next  = step1(wr_reg, md_reg);
        cnt_next = cnt_reg - SHAMT_WIDTH'(1);
      end
    end
  end

  // Datapath registers; reset also clears the result so an aborted
  // operation leaves no stale value visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg   <= '0;
      cnt_reg  <= '0;
      md_reg   <= '0;
      out_data <= '0;
    end else begin
      wr_reg   <= wr_next;
      cnt_reg  <= cnt_next;
      md_reg   <= md_next;
      out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
module tb_shifter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic [3:0]  sh_amt;
  logic [1:0]  mode;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  int vectors = 0;
  int errors  = 0;
  int overlap = 0;

  localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRA = 2'b11;

  shifter_seq #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .sh_amt(sh_amt),
    .mode(mode), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Edges from acceptance to DONE.
  function automatic int exp_lat(input int a);
`ifdef SHIFTER_SEQ_STEP4_EN
    return a / 4 + a % 4 + 1;
`else
    return a + 1;
`endif
  endfunction

  // Reference model built from wide shifts, not from iteration.
  function automatic logic [15:0] ref_shift(input logic [1:0] m, input logic [15:0] d, input int a);
    logic [31:0] t;
    case (m)
      ROL: begin t = {d, d} << a; return t[31:16]; end
      SLL: return d << a;
      ROR: begin t = {d, d} >> a; return t[15:0]; end
      default: return $signed(d) >>> a;
    endcase
  endfunction

  // Present a request at the negedge; return #1 after the accepting edge E0
  // with start dropped and the inputs scrambled.
  task automatic launch(input logic [1:0] m, input logic [15:0] d, input logic [3:0] a);
    @(negedge clk);
    start = 1'b1; mode = m; in_data = d; sh_amt = a;
    @(posedge clk); #1;
    start = 1'b0; in_data = 16'(($urandom)); sh_amt = 4'($urandom); mode = 2'($urandom);
  endtask

  // Step edges after E0 until done is seen (bounded). lat = edge index of
  // DONE entry, or -1 on timeout. busy_n counts busy cycles seen on the way.
  task automatic wait_done(output int lat, output int busy_n);
    lat = -1; busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy && done) overlap++;
      if (done) begin lat = k; break; end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_data = 16'hA5A5; sh_amt = 4'd3; mode = SRA;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    $display("reset: out_data=%h busy=%b done=%b", out_data, busy, done);
  endtask

  task automatic test_sra_latency;
    int lat, bn, busy_tot;
    launch(SRA, 16'h8001, 4'd4);
    busy_tot = busy ? 1 : 0;
    wait_done(lat, bn);
    busy_tot += bn;
    vectors++; if (out_data !== 16'hF800) begin errors++; $display("FAIL sra4_result got=%h exp=f800", out_data); end
    vectors++; if (lat != exp_lat(4)) begin errors++; $display("FAIL sra4_latency got=%0d exp=%0d", lat, exp_lat(4)); end
    vectors++; if (busy_tot != exp_lat(4)) begin errors++; $display("FAIL sra4_busy_cycles got=%0d exp=%0d", busy_tot, exp_lat(4)); end
    $display("sra 8001>>>4: out=%h lat=%0d busy_cycles=%0d", out_data, lat, busy_tot);
    // done must be a single-cycle pulse
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_modes;
    logic [1:0]  tm [7] = '{ROL, ROR, SLL, SRA, SLL, SRA, ROL};
    logic [15:0] td [7] = '{16'h8001, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h00F0};
    int          ta [7] = '{1, 15, 15, 15, 0, 15, 6};
    logic [15:0] te [7] = '{16'h0003, 16'h0002, 16'h8000, 16'h0000, 16'h1234, 16'hFFFF, 16'h3C00};
    int lat, bn;
    for (int i = 0; i < 7; i++) begin
      launch(tm[i], td[i], 4'(ta[i]));
      wait_done(lat, bn);
      vectors++; if (out_data !== te[i]) begin errors++; $display("FAIL mode_vec%0d_result got=%h exp=%h", i, out_data, te[i]); end
      vectors++; if (lat != exp_lat(ta[i])) begin errors++; $display("FAIL mode_vec%0d_latency got=%0d exp=%0d", i, lat, exp_lat(ta[i])); end
      $display("mode=%0d in=%h amt=%0d: out=%h lat=%0d", tm[i], td[i], ta[i], out_data, lat);
    end
  endtask

  task automatic test_hold;
    // Last result was 3C00; it must persist through IDLE.
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (out_data !== 16'h3C00) begin errors++; $display("FAIL hold_idle got=%h exp=3c00", out_data); end
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_flags got=%b%b exp=00", busy, done); end
    $display("hold: out_data=%h in idle", out_data);
  endtask

  task automatic test_start_ignored;
    int lat, bn;
    launch(ROR, 16'h000F, 4'd6);
    // Previous result must still be visible while the new op runs.
    vectors++; if (out_data !== 16'h3C00) begin errors++; $display("FAIL hold_during_shift got=%h exp=3c00", out_data); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; in_data = 16'hFFFF; sh_amt = 4'd1; mode = SLL;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bn);
    lat += 3;
    vectors++; if (out_data !== 16'h3C00) begin errors++; $display("FAIL ignored_start_result got=%h exp=3c00", out_data); end
    vectors++; if (lat != exp_lat(6)) begin errors++; $display("FAIL ignored_start_latency got=%0d exp=%0d", lat, exp_lat(6)); end
    $display("ror 000F by 6 with mid-shift start: out=%h lat=%0d", out_data, lat);
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    launch(SLL, 16'h0001, 4'd3);
    wait_done(lat, bn);
    vectors++; if (out_data !== 16'h0008) begin errors++; $display("FAIL b2b_first got=%h exp=0008", out_data); end
    // In the DONE cycle, present the next request.
    start = 1'b1; in_data = 16'h0180; sh_amt = 4'd5; mode = ROR;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap busy got=%b exp=1", busy); end
    wait_done(lat, bn);
    vectors++; if (out_data !== 16'h000C) begin errors++; $display("FAIL b2b_second got=%h exp=000c", out_data); end
    vectors++; if (lat != exp_lat(5)) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, exp_lat(5)); end
    $display("back-to-back: sll 0001<<3 then ror 0180 by 5: out=%h lat=%0d", out_data, lat);
  endtask

  task automatic test_reset_abort;
    int lat, bn, seen;
    launch(SRA, 16'h8000, 4'd10);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state busy/done got=%b%b exp=00", busy, done); end
    vectors++; if (out_data !== 16'h0000) begin errors++; $display("FAIL abort_out_data got=%h exp=0000", out_data); end
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    vectors++; if (seen != 0) begin errors++; $display("FAIL abort_done_pulses got=%0d exp=0", seen); end
    launch(SRA, 16'h8000, 4'd10);
    wait_done(lat, bn);
    vectors++; if (out_data !== 16'hFFE0) begin errors++; $display("FAIL after_abort_result got=%h exp=ffe0", out_data); end
    vectors++; if (lat != exp_lat(10)) begin errors++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, exp_lat(10)); end
    $display("reset abort then sra 8000>>>10: out=%h lat=%0d", out_data, lat);
  endtask

  task automatic test_random;
    int lat, bn, a;
    logic [1:0] m;
    logic [15:0] d, e;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom); d = 16'($urandom); a = $urandom_range(0, 15);
      e = ref_shift(m, d, a);
      launch(m, d, 4'(a));
      wait_done(lat, bn);
      vectors++; if (out_data !== e || lat != exp_lat(a)) begin
        errors++;
        $display("FAIL random%0d mode=%0d in=%h amt=%0d got=%h/%0d exp=%h/%0d", i, m, d, a, out_data, lat, e, exp_lat(a));
      end
      $display("random%0d mode=%0d in=%h amt=%0d: out=%h lat=%0d", i, m, d, a, out_data, lat);
    end
  endtask

  initial begin
    test_reset;
    test_sra_latency;
    test_modes;
    test_hold;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    test_random;
    vectors++; if (overlap != 0) begin errors++; $display("FAIL busy_done_overlap got=%0d exp=0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
